ps2_kbd_tx: RTL and testbench
=============================

Name: ps2_kbd_tx

Overview:
- Device-side PS/2 keyboard transmitter. It is the sending end of the ps2_kbd_clk/ps2_kbd_data link that the keyboard receiver consumes.
- Accepts scancode bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each byte as an 11-bit PS/2 frame on generated clock/data lines.
- Used for host-side key injection and as the stimulus source for keyboard-receiver benches. Runs on clk_sys (18 MHz in arcade cores).

Parameters:
- CLK_DIV, 720: clk_sys cycles per PS/2 half-period. 720 at 18 MHz gives ~12.5 kHz. Legal range is 2 or more.
- GAP_CYCLES, 1440: idle clk_sys cycles (both lines high) between consecutive frames. Legal range is 1 or more.
- FIFO_AW, 4: FIFO address width; depth is 2**FIFO_AW entries.

Ports:
- clk_sys  in  1  system clock. Only clock in the block.
- res_n_i  in  1  synchronous reset, active-low.
- byte_i  in  8  scancode byte to send.
- valid_i  in  1  byte_i is valid.
- ready_o  out  1  FIFO can accept a byte. Transfer happens on a cycle where valid_i && ready_o.
- ps2_kbd_clk  out  1  generated PS/2 clock; idles high.
- ps2_kbd_data  out  1  PS/2 data; idles high.
- busy_o  out  1  high while a frame or inter-frame gap is in progress, or while the FIFO is non-empty.

Behaviour:
- Reset: while res_n_i=0 at a clk_sys edge, the following are forced: ps2_kbd_clk=1, ps2_kbd_data=1, ready_o=0, busy_o=0, FIFO flushed, FSM=IDLE, bit counter=0.
  - ready_o rises on the first edge after release.
  - Reset mid-frame aborts the frame immediately. There is no partial completion, and the lines return high on the reset edge.
- Frame format, LSB first: start(0), d0..d7, parity, stop(1). Parity = ~^byte (odd parity, so total ones over data+parity is odd).
- Bit timing: each bit occupies 2*CLK_DIV cycles.
  - First CLK_DIV cycles: ps2_kbd_clk=1, ps2_kbd_data=bit value. Data changes only on the first cycle of this high phase.
  - Next CLK_DIV cycles: ps2_kbd_clk=0, data held.
  - Receivers sample on the falling edge, so data is stable for CLK_DIV cycles before each fall.
  - One frame takes 22*CLK_DIV cycles.
- FSM states:
  - IDLE: lines high. On FIFO non-empty, pop the head into the 11-bit shift register (frame pre-assembled) and go to HIGH.
  - HIGH: count CLK_DIV, then go to LOW.
  - LOW: count CLK_DIV. Then, if bit index = 10, go to GAP; otherwise increment the index, shift, and go to HIGH.
  - GAP: lines high. Count GAP_CYCLES, then go to IDLE.
- Latency: a byte accepted at cycle N into an empty FIFO with FSM in IDLE causes ps2_kbd_data to fall (start bit) at N+2.
  - Back-to-back bytes are separated by exactly GAP_CYCLES+1 cycles of idle lines: GAP plus one IDLE cycle for the pop.
- FIFO:
  - ready_o = !full.
  - A push while full cannot occur (ready_o=0). valid_i held high is not an error; the byte is simply not taken.
  - Push and pop on the same cycle is legal when not full; occupancy is unchanged.
  - A pop when empty never occurs.
  - Ordering is strictly FIFO; no byte is dropped or duplicated.
- busy_o = (FSM != IDLE) || !empty. It falls in the cycle after GAP completes with the FIFO empty.
- The counters are wide enough for max(CLK_DIV, GAP_CYCLES). There is no wrap during normal counting.

Optional Feature:
- Macro PS2_KBD_TX_BREAK_EN, when defined:
  - Adds input port break_i (1 bit), sampled with the valid_i/ready_o handshake and stored as a 9th FIFO bit.
  - For an entry with break=1, the FSM first sends a full 0xF0 frame, then GAP, then the byte frame. busy_o stays high throughout.
  - One FIFO entry produces two frames.
- When not defined: no break_i port, the FIFO is 8 bits wide, and every entry produces one frame.

Decomposition:
- Package ps2_kbd_tx_pkg holds:
  - state enum {IDLE, HIGH, LOW, GAP}, plus BRK when the macro is enabled.
  - FRAME_BITS = 11.
  - BREAK_CODE = 8'hF0.
  - a parity/frame-assembly function.
- One sub-module: ps2_tx_fifo, a synchronous FIFO with parameterised width and depth, full/empty flags, and the same clk_sys/res_n_i reset.

Test Plan (run with CLK_DIV=4, GAP_CYCLES=8):
- Reset then push 0x1C at cycle N.
  - Required: data falls at N+2.
  - Sampled at the 11 clock falls: 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - Frame lasts 88 cycles.
- Push 0x00, then 0xFF.
  - Required parity bits: 1 for both.
  - Second start bit begins exactly 9 cycles after the first frame's final LOW phase ends.
- Hold valid_i high with 20 distinct bytes and depth 16.
  - Required: ready_o drops after 16 accepts.
  - All 20 bytes are emitted in order; none are lost.
- Assert res_n_i=0 during bit 5 of a frame.
  - Required: next edge gives clk=1, data=1, busy_o=0, ready_o=0.
  - After release: ready_o=1, and no residual frame is emitted.
- Push while the FIFO is non-empty and a pop occurs in the same cycle.
  - Required: occupancy is unchanged and the output byte order is preserved.
- With PS2_KBD_TX_BREAK_EN, push 0x1C with break_i=1.
  - Required: frame 0xF0 (parity 1), then 8-cycle gap plus pop cycle, then frame 0x1C.
  - busy_o stays high continuously.

Source files
------------

// File: rtl/ps2_kbd_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_tx_pkg
// Description : Shared constants, FSM state encodings and frame assembly for
//               the device-side PS/2 keyboard transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_kbd_tx_pkg;

  // An 11-bit frame: start, 8 data bits, parity, stop
  localparam int FRAME_BITS = 11;

  // Prefix byte sent ahead of a key-release scancode
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // FIFO entry width: a break flag rides alongside the byte when enabled
`ifdef PS2_KBD_TX_BREAK_EN
  localparam int FIFO_W = 9;
`else
  localparam int FIFO_W = 8;
`endif

  // Transmit FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HIGH = 3'd1;
  localparam logic [2:0] ST_LOW  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
`ifdef PS2_KBD_TX_BREAK_EN
  localparam logic [2:0] ST_BRK  = 3'd4;
`endif

  // Pre-assemble a frame, bit 0 is transmitted first.
  // Parity is odd: total ones over data plus parity is odd.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx_fifo
// Description : Synchronous FIFO, 2**AW entries of WIDTH bits, with full and
//               empty flags. Reset flushes the pointers; storage is not
//               cleared since it is never read while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_sys,
  input  logic             res_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int c_depth = 2 ** AW;

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [c_depth];
  logic [WIDTH-1:0] mem_d [c_depth];
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on push and pop; both may happen in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, flushed by reset
  always_ff @(posedge clk_sys) begin
    if (!res_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // One storage word per entry, written only when addressed by a push
  for (genvar gi = 0; gi < c_depth; gi++) begin : g_mem
    // Next value of this entry
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (w_push && (wr_ptr_q[AW-1:0] == AW'(gi))) mem_d[gi] = wdata_i;
    end

    // Entry storage
    always_ff @(posedge clk_sys) begin
      mem_q[gi] <= mem_d[gi];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_tx
// Description : Device-side PS/2 keyboard transmitter. Scancodes enter via a
//               valid/ready handshake into a FIFO and are serialised as
//               11-bit frames on generated PS/2 clock/data lines.
//               Optional macro PS2_KBD_TX_BREAK_EN adds break_i: such an
//               entry is sent as an 0xF0 frame, a gap, then the byte frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_tx
  import ps2_kbd_tx_pkg::*;
#(
  parameter int CLK_DIV    = 720,
  parameter int GAP_CYCLES = 1440,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk_sys,
  input  logic       res_n_i,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
`ifdef PS2_KBD_TX_BREAK_EN
  input  logic       break_i,
`endif
  output logic       ready_o,
  output logic       ps2_kbd_clk,
  output logic       ps2_kbd_data,
  output logic       busy_o
);

  // Counter sized for the longer of a half-period and the gap
  localparam int c_cnt_max = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [3:0]         c_last_bit = 4'(FRAME_BITS - 1);

  logic [2:0]            state_q,   state_d;
  logic [c_cnt_w-1:0]    cnt_q,     cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  // Bits 1..10 of the frame; bit 0 goes straight to the data line on load
  logic [FRAME_BITS-2:0] shreg_q,   shreg_d;
  logic                  ps2_clk_q, ps2_clk_d;
  logic                  ps2_dat_q, ps2_dat_d;
  logic                  rdy_en_q,  rdy_en_d;
`ifdef PS2_KBD_TX_BREAK_EN
  logic                  brk_pend_q,  brk_pend_d;
  logic [7:0]            pend_byte_q, pend_byte_d;
`endif

  logic                  w_push;
  logic                  w_pop;
  logic [FIFO_W-1:0]     w_fifo_wdata;
  logic [FIFO_W-1:0]     w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FRAME_BITS-1:0] w_frame;

  // ready stays low through reset and rises on the first edge after release
  assign ready_o      = rdy_en_q && !w_fifo_full;
  assign w_push       = valid_i && ready_o;
  assign busy_o       = (state_q != ST_IDLE) || !w_fifo_empty;
  assign ps2_kbd_clk  = ps2_clk_q;
  assign ps2_kbd_data = ps2_dat_q;

`ifdef PS2_KBD_TX_BREAK_EN
  assign w_fifo_wdata = {break_i, byte_i};
  // BRK loads the held byte; IDLE loads either the break prefix or the byte
  assign w_frame = (state_q == ST_BRK) ? ps2_frame(pend_byte_q) :
                   (w_fifo_rdata[8]    ? ps2_frame(BREAK_CODE)
                                       : ps2_frame(w_fifo_rdata[7:0]));
`else
  assign w_fifo_wdata = byte_i;
  assign w_frame      = ps2_frame(w_fifo_rdata);
`endif

  ps2_tx_fifo #(
    .WIDTH (FIFO_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .res_n_i (res_n_i),
    .push_i  (w_push),
    .wdata_i (w_fifo_wdata),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Transmit FSM: pop, clock out each bit as a high then low half-period, gap
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    ps2_clk_d = ps2_clk_q;
    ps2_dat_d = ps2_dat_q;
    rdy_en_d  = 1'b1;
    w_pop     = 1'b0;
`ifdef PS2_KBD_TX_BREAK_EN
    brk_pend_d  = brk_pend_q;
    pend_byte_d = pend_byte_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ps2_clk_d = 1'b1;
        ps2_dat_d = 1'b1;
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          state_d   = ST_HIGH;
          cnt_d     = '0;
          bit_idx_d = '0;
          shreg_d   = w_frame[FRAME_BITS-1:1];
          ps2_dat_d = w_frame[0];
`ifdef PS2_KBD_TX_BREAK_EN
          brk_pend_d  = w_fifo_rdata[8];
          pend_byte_d = w_fifo_rdata[7:0];
`endif
        end
      end
      ST_HIGH: begin
        if (cnt_q == c_div_last) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b0;
          state_d   = ST_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt_q == c_div_last) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          if (bit_idx_q == c_last_bit) begin
            ps2_dat_d = 1'b1;
            state_d   = ST_GAP;
          end else begin
            // Data changes only here, at the start of the high phase
            bit_idx_d = bit_idx_q + 1'b1;
            ps2_dat_d = shreg_q[0];
            shreg_d   = {1'b1, shreg_q[FRAME_BITS-2:1]};
            state_d   = ST_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == c_gap_last) begin
          cnt_d = '0;
`ifdef PS2_KBD_TX_BREAK_EN
          state_d = brk_pend_q ? ST_BRK : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PS2_KBD_TX_BREAK_EN
      ST_BRK: begin
        // Second frame of a break entry, mirrors the IDLE pop cycle
        brk_pend_d = 1'b0;
        state_d    = ST_HIGH;
        cnt_d      = '0;
        bit_idx_d  = '0;
        shreg_d    = w_frame[FRAME_BITS-1:1];
        ps2_clk_d  = 1'b1;
        ps2_dat_d  = w_frame[0];
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        ps2_clk_d = 1'b1;
        ps2_dat_d = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame and drives both lines high
  always_ff @(posedge clk_sys) begin
    if (!res_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      ps2_clk_q <= 1'b1;
      ps2_dat_q <= 1'b1;
      rdy_en_q  <= 1'b0;
`ifdef PS2_KBD_TX_BREAK_EN
      brk_pend_q  <= 1'b0;
      pend_byte_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      ps2_clk_q <= ps2_clk_d;
      ps2_dat_q <= ps2_dat_d;
      rdy_en_q  <= rdy_en_d;
`ifdef PS2_KBD_TX_BREAK_EN
      brk_pend_q  <= brk_pend_d;
      pend_byte_q <= pend_byte_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_tx
// Description : Directed self-checking bench for ps2_kbd_tx with CLK_DIV=4,
//               GAP_CYCLES=8. A line monitor decodes frames on the PS/2
//               clock falls and records frame start/end cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int FIFO_AW    = 4;

  logic       clk_sys;
  logic       res_n_i;
  logic [7:0] byte_i;
  logic       valid_i;
`ifdef PS2_KBD_TX_BREAK_EN
  logic       break_i;
`endif
  logic       ready_o;
  logic       ps2_kbd_clk;
  logic       ps2_kbd_data;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Line monitor state
  logic [10:0] rx_q[$];
  int          start_q[$];
  int          end_q[$];
  int          mon_bit   = 0;
  int          fall_cnt  = 0;
  logic [10:0] mon_shift = '0;
  logic        mon_done  = 1'b0;
  logic        mon_pclk  = 1'b1;
  logic        mon_pdata = 1'b1;

  logic [FIFO_AW:0] occ;
  assign occ = dut.u_fifo.wr_ptr_q - dut.u_fifo.rd_ptr_q;

  ps2_kbd_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_AW    (FIFO_AW)
  ) dut (
    .clk_sys      (clk_sys),
    .res_n_i      (res_n_i),
    .byte_i       (byte_i),
    .valid_i      (valid_i),
`ifdef PS2_KBD_TX_BREAK_EN
    .break_i      (break_i),
`endif
    .ready_o      (ready_o),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .busy_o       (busy_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Decode frames: sample data on each PS/2 clock fall
  always @(negedge clk_sys) begin
    if (!res_n_i) begin
      mon_bit  = 0;
      mon_done = 1'b0;
    end else begin
      if (mon_pdata && !ps2_kbd_data && ps2_kbd_clk && mon_bit == 0)
        start_q.push_back(cyc);
      if (mon_pclk && !ps2_kbd_clk) begin
        mon_shift[mon_bit] = ps2_kbd_data;
        fall_cnt++;
        if (mon_bit == 10) begin
          rx_q.push_back(mon_shift);
          mon_bit  = 0;
          mon_done = 1'b1;
        end else begin
          mon_bit++;
        end
      end
      if (!mon_pclk && ps2_kbd_clk && mon_done) begin
        end_q.push_back(cyc);
        mon_done = 1'b0;
      end
    end
    mon_pclk  = ps2_kbd_clk;
    mon_pdata = ps2_kbd_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // One step: just after the falling clk_sys edge
  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  // Offer a byte; leaves valid_i high, returns the accept cycle
  task automatic push(input logic [7:0] b, output int acc);
    byte_i  = b;
    valid_i = 1'b1;
    acc     = -1;
    for (int t = 0; t < 4000; t++) begin
      if (ready_o) begin
        acc = cyc;
        tick();
        break;
      end
      tick();
    end
    if (acc < 0) check_eq("push_timeout", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic wait_ends(input int n);
    for (int t = 0; t < 5000; t++) begin
      if (end_q.size() >= n) break;
      tick();
    end
    if (end_q.size() < n) check_eq("wait_ends_timeout", end_q.size(), n);
  endtask

  task automatic wait_cyc(input int target);
    for (int t = 0; t < 5000; t++) begin
      if (cyc >= target) break;
      tick();
    end
  endtask

  int          acc;
  int          rb, sb, eb, fc, e, lows;
  int          accs[16];
  logic [7:0]  exp_bytes[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n_i = 1'b0;
    valid_i = 1'b0;
    byte_i  = 8'h00;
`ifdef PS2_KBD_TX_BREAK_EN
    break_i = 1'b0;
`endif
    repeat (3) tick();
    check_eq("rst_clk",   {31'd0, ps2_kbd_clk},  32'd1);
    check_eq("rst_data",  {31'd0, ps2_kbd_data}, 32'd1);
    check_eq("rst_ready", {31'd0, ready_o},      32'd0);
    check_eq("rst_busy",  {31'd0, busy_o},       32'd0);
    res_n_i = 1'b1;
    tick();
    check_eq("ready_after_release", {31'd0, ready_o}, 32'd1);

    // ---- single byte 0x1C: latency, bit pattern, frame length
    sb = start_q.size(); eb = end_q.size(); rb = rx_q.size();
    push(8'h1C, acc);
    valid_i = 1'b0;
    wait_ends(eb + 1);
    check_eq("t1_latency",   start_q[sb], acc + 2);
    check_eq("t1_frame",     {21'd0, rx_q[rb]}, {21'd0, 11'b10000111000});
    check_eq("t1_frame_len", end_q[eb] - start_q[sb], 32'd88);
    repeat (12) tick();
    check_eq("t1_busy_idle", {31'd0, busy_o}, 32'd0);

    // ---- 0x00 then 0xFF: parity and inter-frame spacing
    sb = start_q.size(); eb = end_q.size(); rb = rx_q.size();
    push(8'h00, acc);
    push(8'hFF, acc);
    valid_i = 1'b0;
    wait_ends(eb + 2);
    check_eq("t2_frame_00",  {21'd0, rx_q[rb]},     {21'd0, 11'b11000000000});
    check_eq("t2_frame_ff",  {21'd0, rx_q[rb + 1]}, {21'd0, 11'b11111111110});
    check_eq("t2_parity_00", {31'd0, rx_q[rb][9]},     32'd1);
    check_eq("t2_parity_ff", {31'd0, rx_q[rb + 1][9]}, 32'd1);
    check_eq("t2_gap",       start_q[sb + 1] - end_q[eb], 32'd9);
    repeat (12) tick();

    // ---- 20 bytes with valid held: 16 back-to-back accepts fill the FIFO
    eb = end_q.size(); rb = rx_q.size();
    exp_bytes.delete();
    push(8'h31, acc);
    exp_bytes.push_back(8'h31);
    valid_i = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h40 + i), acc);
      accs[i] = acc;
      exp_bytes.push_back(8'(8'h40 + i));
    end
    check_eq("t3_burst_span", accs[15] - accs[0], 32'd15);
    check_eq("t3_ready_full", {31'd0, ready_o}, 32'd0);
    for (int i = 16; i < 19; i++) begin
      push(8'(8'h40 + i), acc);
      exp_bytes.push_back(8'(8'h40 + i));
    end
    valid_i = 1'b0;
    wait_ends(eb + 20);
    for (int i = 0; i < 20; i++)
      check_eq($sformatf("t3_frame_%0d", i), {21'd0, rx_q[rb + i]},
               {21'd0, exp_frame(exp_bytes[i])});
    repeat (12) tick();

    // ---- reset during bit 5 with a second byte queued
    sb = start_q.size(); rb = rx_q.size();
    push(8'hA5, acc);
    push(8'h5A, acc);
    valid_i = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (mon_bit == 5) break;
      tick();
    end
    check_eq("t4_reached_bit5", mon_bit, 32'd5);
    res_n_i = 1'b0;
    tick();
    check_eq("t4_rst_clk",   {31'd0, ps2_kbd_clk},  32'd1);
    check_eq("t4_rst_data",  {31'd0, ps2_kbd_data}, 32'd1);
    check_eq("t4_rst_busy",  {31'd0, busy_o},       32'd0);
    check_eq("t4_rst_ready", {31'd0, ready_o},      32'd0);
    res_n_i = 1'b1;
    fc = fall_cnt;
    tick();
    check_eq("t4_ready_release", {31'd0, ready_o}, 32'd1);
    repeat (300) tick();
    check_eq("t4_no_falls",  fall_cnt, fc);
    check_eq("t4_no_frames", rx_q.size(), rb);
    check_eq("t4_no_starts", start_q.size(), sb + 1);
    check_eq("t4_idle_busy", {31'd0, busy_o}, 32'd0);

    // ---- push on the same cycle as a pop
    sb = start_q.size(); eb = end_q.size(); rb = rx_q.size();
    push(8'h11, acc);
    valid_i = 1'b0;
    repeat (4) tick();
    push(8'h22, acc);
    valid_i = 1'b0;
    wait_ends(eb + 1);
    e = end_q[eb];
    wait_cyc(e + 8);
    check_eq("t5_occ_before", {27'd0, occ}, 32'd1);
    push(8'h33, acc);
    valid_i = 1'b0;
    check_eq("t5_accept_cyc", acc, e + 8);
    check_eq("t5_occ_after",  {27'd0, occ}, 32'd1);
    wait_ends(eb + 3);
    check_eq("t5_frame_11", {21'd0, rx_q[rb]},     {21'd0, exp_frame(8'h11)});
    check_eq("t5_frame_22", {21'd0, rx_q[rb + 1]}, {21'd0, exp_frame(8'h22)});
    check_eq("t5_frame_33", {21'd0, rx_q[rb + 2]}, {21'd0, exp_frame(8'h33)});
    check_eq("t5_start_22", start_q[sb + 1], e + 9);
    repeat (12) tick();

`ifdef PS2_KBD_TX_BREAK_EN
    // ---- break entry: 0xF0 frame, gap plus pop cycle, then the byte
    sb = start_q.size(); eb = end_q.size(); rb = rx_q.size();
    break_i = 1'b1;
    push(8'h1C, acc);
    valid_i = 1'b0;
    break_i = 1'b0;
    lows = 0;
    for (int t = 0; t < 1000; t++) begin
      if (end_q.size() >= eb + 2) break;
      if (!busy_o) lows++;
      tick();
    end
    wait_ends(eb + 2);
    check_eq("brk_busy_held", lows, 32'd0);
    check_eq("brk_frame_f0",  {21'd0, rx_q[rb]},     {21'd0, 11'b11111100000});
    check_eq("brk_frame_1c",  {21'd0, rx_q[rb + 1]}, {21'd0, 11'b10000111000});
    check_eq("brk_gap",       start_q[sb + 1] - end_q[eb], 32'd9);
    repeat (12) tick();
    check_eq("brk_busy_idle", {31'd0, busy_o}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
